mem_arbiter: RTL and testbench

Shares the single-port unified instruction/data memory between the fetch stage and the MEM stage of the pipelined MIPS core. It arbitrates between the instruction-fetch port and the data port, which is driven by the decoded `readmem`/`writemem` control lines carried down the pipeline. It runs one transaction at a time over a ready-handshaked memory bus and returns read data to the winner. It drives per-port stall lines that the hazard logic uses to freeze the pipeline.

---
 rtl/mem_arbiter_if.sv | 52 +++++
 rtl/mem_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch port, data port and memory bus of the
// unified-memory arbiter, bundled for connection to the core.
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // fetch port
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_done;
   // data port
   logic              d_readmem;
   logic              d_writemem;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_done;
   // memory bus
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;
   // pipeline control
   logic              stall_if;
   logic              stall_mem;
   logic              busy;

   // arbiter side
   modport master (
      input  if_req, if_addr,
      output if_rdata, if_done,
      input  d_readmem, d_writemem, d_addr, d_wdata,
      output d_rdata, d_done,
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready,
      output stall_if, stall_mem, busy
   );

   // core and memory side
   modport slave (
      output if_req, if_addr,
      input  if_rdata, if_done,
      output d_readmem, d_writemem, d_addr, d_wdata,
      input  d_rdata, d_done,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ready,
      input  stall_if, stall_mem, busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: one transaction at a time to the unified memory;
// data beats fetch unless fetch has waited STARVE_LIM data grants.
module mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_LIM = 4
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.master bus
);

   typedef enum logic [1:0] {
      IDLE,
      IF_BUSY,
      D_BUSY
   } state_t;

   localparam logic [3:0] LIM = 4'(STARVE_LIM);

   state_t            state_q, state_d;
   logic [3:0]        starve_cnt_q, starve_cnt_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              mem_we_q, mem_we_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              if_done_q, if_done_d;
   logic              d_done_q, d_done_d;

   logic d_any;
   logic if_elig;
   logic d_elig;
   logic starved;
   logic fetch_win;
   logic data_win;

   // A request on its own done cycle is masked so it is not
   // re-granted before the stage has had a chance to drop it.
   assign d_any     = bus.d_readmem | bus.d_writemem;
   assign if_elig   = bus.if_req & ~if_done_q;
   assign d_elig    = d_any & ~d_done_q;
   assign starved   = (starve_cnt_q == LIM);
   assign fetch_win = if_elig & (~d_elig | starved);
   assign data_win  = d_elig & ~fetch_win;

   // Next-state, grant and completion logic
   always_comb begin
      state_d      = state_q;
      starve_cnt_d = starve_cnt_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_we_d     = mem_we_q;
      if_rdata_d   = if_rdata_q;
      d_rdata_d    = d_rdata_q;
      if_done_d    = 1'b0;
      d_done_d     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (fetch_win) begin
               state_d      = IF_BUSY;
               mem_addr_d   = bus.if_addr;
               mem_we_d     = 1'b0;
               starve_cnt_d = 4'd0;
            end else if (data_win) begin
               state_d    = D_BUSY;
               mem_addr_d = bus.d_addr;
               // read+write together is served as a write
               mem_we_d   = bus.d_writemem;
               if (bus.d_writemem) begin
                  mem_wdata_d = bus.d_wdata;
               end
               if (if_elig && (starve_cnt_q < LIM)) begin
                  starve_cnt_d = starve_cnt_q + 4'd1;
               end
            end
         end
         IF_BUSY: begin
            if (bus.mem_ready) begin
               if_rdata_d = bus.mem_rdata;
               if_done_d  = 1'b1;
               state_d    = IDLE;
            end
         end
         D_BUSY: begin
            if (bus.mem_ready) begin
               if (!mem_we_q) begin
                  d_rdata_d = bus.mem_rdata;
               end
               d_done_d = 1'b1;
               state_d  = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset abandons any transaction
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         starve_cnt_q <= 4'd0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_we_q     <= 1'b0;
         if_rdata_q   <= '0;
         d_rdata_q    <= '0;
         if_done_q    <= 1'b0;
         d_done_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_we_q     <= mem_we_d;
         if_rdata_q   <= if_rdata_d;
         d_rdata_q    <= d_rdata_d;
         if_done_q    <= if_done_d;
         d_done_q     <= d_done_d;
      end
   end

   assign bus.mem_req   = (state_q != IDLE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.if_done   = if_done_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.d_done    = d_done_q;
   assign bus.stall_if  = bus.if_req & ~if_done_q;
   assign bus.stall_mem = d_any & ~d_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a scoreboard of expected
// grants and done responses, checked by a separate monitor.
module tb_mem_arbiter;

   localparam int LIM = 4;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
   } grant_t;

   typedef struct {
      logic [31:0] data;
      int          cyc;
   } done_t;

   logic clk;
   logic rst;
   int   cyc;
   int   checks;
   int   errors;

   grant_t gq[$];
   done_t  iq[$];
   done_t  dq[$];

   logic [31:0] mem [logic [31:0]];
   int          waits;
   int          wcnt;
   logic        resp_en;
   logic        man_ready;

   mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_arbiter #(
      .ADDR_W(32),
      .DATA_W(32),
      .STARVE_LIM(LIM)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // cycle counter used to time done pulses
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] mem_rd(logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return a ^ 32'hA5A5_A5A5;
   endfunction

   task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // memory model: W wait cycles, then one ready cycle
   always @(posedge clk) begin
      #2;
      if (!resp_en) begin
         bus.mem_ready = man_ready;
         wcnt = 0;
      end else if (bus.mem_req) begin
         if (wcnt >= waits) begin
            bus.mem_ready = 1'b1;
            if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
            else bus.mem_rdata = mem_rd(bus.mem_addr);
         end else begin
            bus.mem_ready = 1'b0;
            wcnt++;
         end
      end else begin
         bus.mem_ready = 1'b0;
         wcnt = 0;
      end
   end

   logic   req_prev = 1'b0;
   logic   ifd_prev = 1'b0;
   logic   dd_prev = 1'b0;
   grant_t g;
   done_t  e;

   // monitor: checks grants and done pulses against the queues
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.mem_req && !req_prev) begin
            if (gq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL grant: unexpected at %h", bus.mem_addr);
            end else begin
               g = gq.pop_front();
               chk("grant_addr", bus.mem_addr, g.addr);
               chk("grant_we", 32'(bus.mem_we), 32'(g.we));
               if (g.we) chk("grant_wdata", bus.mem_wdata, g.wdata);
            end
         end
         if (bus.if_done) begin
            chk("if_done_width", 32'(ifd_prev), 0);
            if (iq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL if_done: unexpected pulse");
            end else begin
               e = iq.pop_front();
               chk("if_rdata", bus.if_rdata, e.data);
               if (e.cyc >= 0) chk("if_done_cyc", cyc, e.cyc);
            end
         end
         if (bus.d_done) begin
            chk("d_done_width", 32'(dd_prev), 0);
            if (dq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL d_done: unexpected pulse");
            end else begin
               e = dq.pop_front();
               chk("d_rdata", bus.d_rdata, e.data);
               if (e.cyc >= 0) chk("d_done_cyc", cyc, e.cyc);
            end
         end
         if (bus.if_done || bus.d_done)
            chk("done_excl", 32'(bus.if_done & bus.d_done), 0);
      end
      req_prev = bus.mem_req;
      ifd_prev = bus.if_done;
      dd_prev  = bus.d_done;
   end

   task automatic do_data(logic rd, logic wr, logic [31:0] a,
                          logic [31:0] wd, logic [31:0] exp_rd);
      int  t0;
      bit  fin;
      t0 = cyc;
      fin = 0;
      gq.push_back('{addr: a, we: wr, wdata: wd});
      dq.push_back('{data: exp_rd, cyc: t0 + 2 + waits});
      bus.d_readmem  = rd;
      bus.d_writemem = wr;
      bus.d_addr     = a;
      bus.d_wdata    = wd;
      for (int i = 0; i < 40 && !fin; i++) begin
         tick();
         if (bus.d_done) begin
            bus.d_readmem  = 1'b0;
            bus.d_writemem = 1'b0;
            fin = 1;
         end
      end
      if (!fin) begin
         checks++;
         errors++;
         $display("FAIL data_timeout: no d_done for %h", a);
      end
      tick();
   endtask

   int t0;
   int nd;
   bit fin;
   bit fgrant;

   initial begin
      checks = 0;
      errors = 0;
      cyc = 0;
      waits = 0;
      wcnt = 0;
      resp_en = 1'b1;
      man_ready = 1'b0;
      rst = 1'b1;
      bus.if_req = 0;
      bus.if_addr = '0;
      bus.d_readmem = 0;
      bus.d_writemem = 0;
      bus.d_addr = '0;
      bus.d_wdata = '0;
      bus.mem_rdata = '0;
      bus.mem_ready = 0;
      mem[32'h0040_0000] = 32'h2008_0005;
      mem[32'h0040_0004] = 32'h0109_5020;
      mem[32'h0040_0008] = 32'h8D09_0000;
      mem[32'h0040_000C] = 32'hAC0A_0004;
      mem[32'h1000_0004] = 32'h0000_0042;

      tick();
      tick();
      chk("rst_mem_req", 32'(bus.mem_req), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_mem_we", 32'(bus.mem_we), 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_if_rdata", bus.if_rdata, 0);
      chk("rst_d_rdata", bus.d_rdata, 0);
      chk("rst_dones", 32'({bus.if_done, bus.d_done}), 0);
      rst = 1'b0;
      tick();

      // lone fetch, zero-wait, request held through done cycle
      t0 = cyc;
      gq.push_back('{addr: 32'h0040_0000, we: 1'b0, wdata: '0});
      iq.push_back('{data: 32'h2008_0005, cyc: t0 + 2});
      bus.if_req = 1;
      bus.if_addr = 32'h0040_0000;
      tick();
      chk("t1_req_c1", 32'(bus.mem_req), 1);
      chk("t1_stall_c1", 32'(bus.stall_if), 1);
      tick();
      chk("t1_stall_c2", 32'(bus.stall_if), 0);
      tick();
      bus.if_req = 0;
      chk("t1_nogrant_c3", 32'(bus.mem_req), 0);
      tick();
      chk("t1_nogrant_c4", 32'(bus.mem_req), 0);

      // fetch held two cycles past done is granted again
      t0 = cyc;
      gq.push_back('{addr: 32'h0040_0004, we: 1'b0, wdata: '0});
      iq.push_back('{data: 32'h0109_5020, cyc: t0 + 2});
      bus.if_req = 1;
      bus.if_addr = 32'h0040_0004;
      tick();
      tick();
      tick();
      gq.push_back('{addr: 32'h0040_0004, we: 1'b0, wdata: '0});
      iq.push_back('{data: 32'h0109_5020, cyc: t0 + 5});
      tick();
      chk("t6_regrant_c4", 32'(bus.mem_req), 1);
      tick();
      bus.if_req = 0;
      tick();

      // fetch and lw together, two wait states: data first
      waits = 2;
      t0 = cyc;
      gq.push_back('{addr: 32'h1000_0004, we: 1'b0, wdata: '0});
      gq.push_back('{addr: 32'h0040_0008, we: 1'b0, wdata: '0});
      dq.push_back('{data: 32'h0000_0042, cyc: t0 + 4});
      iq.push_back('{data: 32'h8D09_0000, cyc: t0 + 8});
      bus.if_req = 1;
      bus.if_addr = 32'h0040_0008;
      bus.d_readmem = 1;
      bus.d_addr = 32'h1000_0004;
      tick();
      chk("t2_stall_mem", 32'(bus.stall_mem), 1);
      fin = 0;
      for (int i = 0; i < 20 && !fin; i++) begin
         tick();
         if (bus.d_done) begin
            bus.d_readmem = 0;
            chk("t2_idle_gap", 32'(bus.mem_req), 0);
         end
         if (bus.if_done) begin
            bus.if_req = 0;
            fin = 1;
         end
      end
      if (!fin) begin
         checks++;
         errors++;
         $display("FAIL t2_timeout: fetch not served");
      end
      tick();

      // sw, then read+write (served as write), then read back
      waits = 1;
      do_data(1'b0, 1'b1, 32'h1000_0000, 32'hDEAD_BEEF, 32'h0000_0042);
      do_data(1'b1, 1'b1, 32'h1000_0008, 32'h1234_5678, 32'h0000_0042);
      waits = 3;
      do_data(1'b1, 1'b0, 32'h1000_0000, '0, 32'hDEAD_BEEF);
      do_data(1'b1, 1'b0, 32'h1000_0008, '0, 32'h1234_5678);

      // starvation: fetch withdraws on data-done cycles, so data
      // keeps winning until the counter saturates
      waits = 0;
      for (int i = 0; i < LIM; i++) begin
         gq.push_back('{addr: 32'h1000_0004, we: 1'b0, wdata: '0});
         dq.push_back('{data: 32'h0000_0042, cyc: -1});
      end
      gq.push_back('{addr: 32'h0040_000C, we: 1'b0, wdata: '0});
      iq.push_back('{data: 32'hAC0A_0004, cyc: -1});
      bus.d_readmem = 1;
      bus.d_addr = 32'h1000_0004;
      bus.if_req = 1;
      bus.if_addr = 32'h0040_000C;
      nd = 0;
      fin = 0;
      fgrant = 0;
      for (int i = 0; i < 60 && !fin; i++) begin
         tick();
         if (bus.d_done) begin
            nd++;
            bus.if_req = 0;
            if (nd == LIM)
               chk("t4_starve_full", 32'(dut.starve_cnt_q), LIM);
         end else begin
            bus.if_req = 1;
         end
         if (bus.mem_req && !fgrant &&
             bus.mem_addr == 32'h0040_000C) begin
            fgrant = 1;
            bus.d_readmem = 0;
            chk("t4_starve_clr", 32'(dut.starve_cnt_q), 0);
            chk("t4_data_grants", nd, LIM);
         end
         if (bus.if_done) begin
            bus.if_req = 0;
            fin = 1;
         end
      end
      if (!fin) begin
         checks++;
         errors++;
         $display("FAIL t4_timeout: fetch starved");
      end
      tick();

      // reset while D_BUSY waits on memory
      waits = 10;
      gq.push_back('{addr: 32'h1000_0004, we: 1'b0, wdata: '0});
      bus.d_readmem = 1;
      bus.d_addr = 32'h1000_0004;
      tick();
      chk("t5_req", 32'(bus.mem_req), 1);
      tick();
      chk("t5_busy", 32'(bus.busy), 1);
      rst = 1;
      bus.d_readmem = 0;
      tick();
      chk("t5_req_off", 32'(bus.mem_req), 0);
      chk("t5_busy_off", 32'(bus.busy), 0);
      chk("t5_no_done", 32'(bus.d_done), 0);
      chk("t5_d_rdata", bus.d_rdata, 0);
      rst = 0;
      resp_en = 0;
      man_ready = 1;
      tick();
      man_ready = 0;
      chk("t5_late_ready", 32'(bus.mem_req), 0);
      tick();
      chk("t5_late_done", 32'(bus.d_done), 0);
      chk("t5_late_rdata", bus.d_rdata, 0);
      tick();
      resp_en = 1;

      chk("q_grants_left", gq.size(), 0);
      chk("q_if_left", iq.size(), 0);
      chk("q_d_left", dq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
